// File: rtl/sudoku_defs_pkg.sv
// Shared defaults and FSM encoding for the sudoku cell entry path.
package sudoku_defs_pkg;

    localparam int GRID_N_DEF = 9;
    localparam int AW_DEF     = 7;
    localparam int DW_DEF     = 4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_IDLE  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/sudoku_cursor.sv
// Board cursor: wrap-around row/column moves with U > D > L > R priority
// and the registered RAM address of the cursor cell.
module sudoku_cursor
    import sudoku_defs_pkg::*;
#(
    parameter int GRID_N = GRID_N_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          en,
    input  logic          U,
    input  logic          D,
    input  logic          L,
    input  logic          R,
    output logic          moved,
    output logic [3:0]    cur_row,
    output logic [3:0]    cur_col,
    output logic [AW-1:0] mem_addr
);

    localparam logic [3:0] LAST = 4'(GRID_N - 1);

    logic [3:0] row_nxt;
    logic [3:0] col_nxt;

    assign moved = en & (U | D | L | R);

    always_comb begin
        row_nxt = cur_row;
        col_nxt = cur_col;
        if (U)
            row_nxt = (cur_row == 4'd0) ? LAST : cur_row - 4'd1;
        else if (D)
            row_nxt = (cur_row == LAST) ? 4'd0 : cur_row + 4'd1;
        else if (L)
            col_nxt = (cur_col == 4'd0) ? LAST : cur_col - 4'd1;
        else if (R)
            col_nxt = (cur_col == LAST) ? 4'd0 : cur_col + 4'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_row  <= 4'd0;
            cur_col  <= 4'd0;
            mem_addr <= '0;
        end else if (moved) begin
            cur_row  <= row_nxt;
            cur_col  <= col_nxt;
            mem_addr <= AW'(row_nxt) * AW'(GRID_N) + AW'(col_nxt);
        end
    end

endmodule

// File: rtl/sudoku_cell_entry_ctrl.sv
// Cursor-driven cell editor: fetches the cursor cell from board RAM and
// commits the switch digit on C unless the cell is fixed, the digit is
// out of range, or a solution check holds the board.
module sudoku_cell_entry_ctrl
    import sudoku_defs_pkg::*;
#(
    parameter int GRID_N = GRID_N_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          U,
    input  logic          D,
    input  logic          L,
    input  logic          R,
    input  logic          C,
    input  logic [DW-1:0] userIn,
    input  logic          CheckSolu,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          mem_fixed,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wr_data,
    output logic [3:0]    cur_row,
    output logic [3:0]    cur_col,
    output logic [DW-1:0] cur_val,
    output logic          cur_fixed,
    output logic          busy,
    output logic          wr_done,
    output logic          reject
);

    state_t state;
    logic   moved;
    logic   legal;

    assign legal = !CheckSolu && !cur_fixed && (userIn <= DW'(GRID_N));

    sudoku_cursor #(
        .GRID_N (GRID_N),
        .AW     (AW)
    ) u_cursor (
        .Clk      (Clk),
        .Reset    (Reset),
        .en       (state == S_IDLE && !C),
        .U        (U),
        .D        (D),
        .L        (L),
        .R        (R),
        .moved    (moved),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .mem_addr (mem_addr)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_FETCH;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            cur_val     <= '0;
            cur_fixed   <= 1'b0;
            busy        <= 1'b0;
            wr_done     <= 1'b0;
            reject      <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            reject  <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    mem_rd_en <= 1'b1;
                    busy      <= 1'b1;
                    state     <= S_WAIT;
                end
                // First WAIT edge is the RAM's read edge; data lands on the next.
                S_WAIT: begin
                    if (mem_rd_en) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        cur_val   <= mem_rd_data;
                        cur_fixed <= mem_fixed;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (C) begin
                        if (legal) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= userIn;
                            busy        <= 1'b1;
                            state       <= S_WRITE;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (moved) begin
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_WRITE: begin
                    mem_wr_en <= 1'b0;
                    cur_val   <= mem_wr_data;
                    wr_done   <= 1'b1;
                    state     <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_cell_entry_ctrl.sv
// Directed bench for sudoku_cell_entry_ctrl with a 1-cycle-latency RAM model.
module tb_sudoku_cell_entry_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       U = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0, C = 1'b0;
    logic       CheckSolu = 1'b0;
    logic [3:0] userIn = 4'd0;
    logic [6:0] mem_addr;
    logic       mem_rd_en;
    logic [3:0] mem_rd_data;
    logic       mem_fixed;
    logic       mem_wr_en;
    logic [3:0] mem_wr_data;
    logic [3:0] cur_row, cur_col, cur_val;
    logic       cur_fixed, busy, wr_done, reject;

    int vecs = 0;
    int errs = 0;

    logic [3:0] ram [128];
    logic       fix [128];
    logic       pl_en = 1'b0;
    logic [6:0] pl_addr = 7'd0;
    logic [3:0] pl_data = 4'd0;
    logic       pl_fix = 1'b0;
    logic       wr_seen = 1'b0;
    logic       wr_clr = 1'b0;

    always #5 Clk = ~Clk;

    sudoku_cell_entry_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .U           (U),
        .D           (D),
        .L           (L),
        .R           (R),
        .C           (C),
        .userIn      (userIn),
        .CheckSolu   (CheckSolu),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .mem_fixed   (mem_fixed),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .cur_row     (cur_row),
        .cur_col     (cur_col),
        .cur_val     (cur_val),
        .cur_fixed   (cur_fixed),
        .busy        (busy),
        .wr_done     (wr_done),
        .reject      (reject)
    );

    always @(posedge Clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
            fix[pl_addr] <= pl_fix;
        end
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) begin
            mem_rd_data <= ram[mem_addr];
            mem_fixed   <= fix[mem_addr];
        end
        if (wr_clr) wr_seen <= 1'b0;
        else if (mem_wr_en) wr_seen <= 1'b1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic u, d, l, r, c);
        U = u; D = d; L = l; R = r; C = c;
        step();
        U = 0; D = 0; L = 0; R = 0; C = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic move(input logic u, d, l, r);
        pulse(u, d, l, r, 1'b0);
        wait_idle();
    endtask

    task automatic preload(input int a, input int v, input logic f);
        pl_en = 1'b1; pl_addr = 7'(a); pl_data = 4'(v); pl_fix = f;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 128; i++) preload(i, 0, 1'b0);
        preload(0, 5, 1'b0);
        preload(72, 3, 1'b0);
        preload(80, 6, 1'b0);
        preload(21, 1, 1'b0);
        preload(22, 4, 1'b1);
        vecs++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            errs++;
            $display("FAIL rst_outs: rd=%b busy=%b wr=%b want 0 0 0", mem_rd_en, busy, mem_wr_en);
        end
        vecs++;
        if (cur_row !== 4'd0 || cur_col !== 4'd0 || mem_addr !== 7'd0 || cur_val !== 4'd0) begin
            errs++;
            $display("FAIL rst_cursor: row=%0d col=%0d addr=%0d val=%0d want 0 0 0 0",
                     cur_row, cur_col, mem_addr, cur_val);
        end
        Reset = 1'b0;
        step();
        vecs++;
        if (mem_rd_en !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL rst_fetch: rd=%b busy=%b want 1 1", mem_rd_en, busy);
        end
        step();
        step();
        vecs++;
        if (cur_val !== 4'd5 || busy !== 1'b0 || cur_fixed !== 1'b0) begin
            errs++;
            $display("FAIL rst_first_read: val=%0d busy=%b fix=%b want 5 0 0", cur_val, busy, cur_fixed);
        end
    endtask

    task automatic test_moves();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (cur_row !== 4'd8 || cur_col !== 4'd0 || mem_addr !== 7'd72 || busy !== 1'b1) begin
            errs++;
            $display("FAIL move_u_wrap: row=%0d col=%0d addr=%0d busy=%b want 8 0 72 1",
                     cur_row, cur_col, mem_addr, busy);
        end
        step(); step(); step();
        vecs++;
        if (cur_val !== 4'd3 || busy !== 1'b0) begin
            errs++;
            $display("FAIL move_latency: val=%0d busy=%b want 3 0", cur_val, busy);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (cur_row !== 4'd8 || cur_col !== 4'd8 || mem_addr !== 7'd80) begin
            errs++;
            $display("FAIL move_l_wrap: row=%0d col=%0d addr=%0d want 8 8 80", cur_row, cur_col, mem_addr);
        end
        wait_idle();
        vecs++;
        if (cur_val !== 4'd6) begin
            errs++;
            $display("FAIL move_l_val: got %0d want 6", cur_val);
        end
        move(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (cur_col !== 4'd0 || mem_addr !== 7'd72) begin
            errs++;
            $display("FAIL move_r_wrap: col=%0d addr=%0d want 0 72", cur_col, mem_addr);
        end
        move(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (cur_row !== 4'd0 || mem_addr !== 7'd0) begin
            errs++;
            $display("FAIL move_d_wrap: row=%0d addr=%0d want 0 0", cur_row, mem_addr);
        end
        move(1'b0, 1'b1, 1'b0, 1'b0);
        move(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) move(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (cur_row !== 4'd2 || cur_col !== 4'd3 || mem_addr !== 7'd21 || cur_val !== 4'd1) begin
            errs++;
            $display("FAIL move_nav: row=%0d col=%0d addr=%0d val=%0d want 2 3 21 1",
                     cur_row, cur_col, mem_addr, cur_val);
        end
    endtask

    task automatic test_commit();
        userIn = 4'd7;
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        userIn = 4'd2;
        vecs++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 7'd21 || mem_wr_data !== 4'd7) begin
            errs++;
            $display("FAIL commit_wr: en=%b addr=%0d data=%0d want 1 21 7", mem_wr_en, mem_addr, mem_wr_data);
        end
        step();
        vecs++;
        if (wr_done !== 1'b1 || mem_wr_en !== 1'b0 || cur_val !== 4'd7) begin
            errs++;
            $display("FAIL commit_done: done=%b en=%b val=%0d want 1 0 7", wr_done, mem_wr_en, cur_val);
        end
        wait_idle();
        vecs++;
        if (cur_val !== 4'd7 || ram[21] !== 4'd7) begin
            errs++;
            $display("FAIL commit_reread: val=%0d ram=%0d want 7 7", cur_val, ram[21]);
        end
    endtask

    task automatic test_reject();
        move(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (cur_fixed !== 1'b1 || cur_val !== 4'd4) begin
            errs++;
            $display("FAIL rej_fixed_read: fix=%b val=%0d want 1 4", cur_fixed, cur_val);
        end
        wr_clr = 1'b1;
        step();
        wr_clr = 1'b0;
        userIn = 4'd3;
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (reject !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rej_fixed: reject=%b busy=%b want 1 0", reject, busy);
        end
        step();
        vecs++;
        if (reject !== 1'b0) begin
            errs++;
            $display("FAIL rej_one_cycle: reject=%b want 0", reject);
        end
        move(1'b0, 1'b0, 1'b0, 1'b1);
        userIn = 4'd12;
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (reject !== 1'b1) begin
            errs++;
            $display("FAIL rej_range: reject=%b want 1", reject);
        end
        step();
        userIn = 4'd9;
        CheckSolu = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (reject !== 1'b1) begin
            errs++;
            $display("FAIL rej_check: reject=%b want 1", reject);
        end
        move(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (cur_row !== 4'd3 || cur_col !== 4'd5) begin
            errs++;
            $display("FAIL check_move: row=%0d col=%0d want 3 5", cur_row, cur_col);
        end
        move(1'b1, 1'b0, 1'b0, 1'b0);
        CheckSolu = 1'b0;
        vecs++;
        if (wr_seen !== 1'b0) begin
            errs++;
            $display("FAIL rej_no_write: wr_seen=%b want 0", wr_seen);
        end
    endtask

    task automatic test_back_to_back();
        userIn = 4'd9;
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (mem_wr_en !== 1'b1 || cur_row !== 4'd2 || cur_col !== 4'd5 ||
            mem_addr !== 7'd23 || mem_wr_data !== 4'd9) begin
            errs++;
            $display("FAIL c_over_u: en=%b row=%0d col=%0d addr=%0d data=%0d want 1 2 5 23 9",
                     mem_wr_en, cur_row, cur_col, mem_addr, mem_wr_data);
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (wr_done !== 1'b1 || cur_row !== 4'd2) begin
            errs++;
            $display("FAIL busy_drop: done=%b row=%0d want 1 2", wr_done, cur_row);
        end
        wait_idle();
        vecs++;
        if (cur_row !== 4'd2 || cur_val !== 4'd9 || ram[23] !== 4'd9) begin
            errs++;
            $display("FAIL max_digit: row=%0d val=%0d ram=%0d want 2 9 9", cur_row, cur_val, ram[23]);
        end
        move(1'b0, 1'b1, 1'b1, 1'b0);
        vecs++;
        if (cur_row !== 4'd3 || cur_col !== 4'd5) begin
            errs++;
            $display("FAIL prio_d_l: row=%0d col=%0d want 3 5", cur_row, cur_col);
        end
        move(1'b0, 1'b0, 1'b1, 1'b1);
        vecs++;
        if (cur_row !== 4'd3 || cur_col !== 4'd4 || mem_addr !== 7'd31) begin
            errs++;
            $display("FAIL prio_l_r: row=%0d col=%0d addr=%0d want 3 4 31", cur_row, cur_col, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        userIn = 4'd1;
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (mem_wr_en !== 1'b1) begin
            errs++;
            $display("FAIL mid_wr_start: en=%b want 1", mem_wr_en);
        end
        #2 Reset = 1'b1;
        #1;
        vecs++;
        if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || cur_row !== 4'd0 ||
            cur_col !== 4'd0 || mem_addr !== 7'd0) begin
            errs++;
            $display("FAIL mid_rst_async: wr=%b rd=%b row=%0d col=%0d addr=%0d want 0 0 0 0 0",
                     mem_wr_en, mem_rd_en, cur_row, cur_col, mem_addr);
        end
        #2 Reset = 1'b0;
        step();
        vecs++;
        if (mem_rd_en !== 1'b1) begin
            errs++;
            $display("FAIL mid_refetch: rd=%b want 1", mem_rd_en);
        end
        wait_idle();
        vecs++;
        if (cur_val !== 4'd5 || ram[31] !== 4'd0) begin
            errs++;
            $display("FAIL mid_after: val=%0d ram31=%0d want 5 0", cur_val, ram[31]);
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_commit();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
